// File: rtl/led_uart_reporter.sv
// led_uart_reporter: free-running LED counter; every increment is reported over a
// UART as uppercase hex (MSB nibble first), optionally followed by CR LF.
module led_uart_reporter #(
   parameter int WIDTH        = 4,
   parameter int TICK_CYCLES  = 50_000_000,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int SEND_CRLF    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] led,
   output logic             tx,
   output logic             busy,
   output logic             overrun
);
   localparam int NDIG  = (WIDTH + 3) / 4;
   localparam int NCHAR = NDIG + 2 * SEND_CRLF;
   localparam int PW    = 4 * NDIG;
   localparam int DW    = $clog2(TICK_CYCLES);
   localparam int CW    = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t           r_state, w_next;
   logic [DW-1:0]    r_div;
   logic [WIDTH-1:0] r_led, r_snap, r_pendVal;
   logic             r_pending, r_overrun, r_tx, r_busy;
   logic [CW-1:0]    r_clkCnt;
   logic [2:0]       r_bitIdx;
   logic [3:0]       r_charIdx;

   logic             w_tick, w_bitDone, w_stopDone, w_lastChar, w_frameEnd;
   logic             w_txNext, w_parity;
   logic [WIDTH-1:0] w_newVal;
   logic [PW-1:0]    w_padded, w_shifted;
   logic [3:0]       w_nib;
   logic [7:0]       w_char;

   assign w_tick     = en && (r_div == DW'(TICK_CYCLES - 1));
   assign w_newVal   = r_led + WIDTH'(1);
   assign w_bitDone  = (r_clkCnt == CW'(CLKS_PER_BIT - 1));
   assign w_lastChar = (r_charIdx == 4'(NCHAR - 1));
   assign w_stopDone = (r_state == STOP) && w_bitDone && (r_bitIdx == 3'(STOP_BITS - 1));
   assign w_frameEnd = w_stopDone && w_lastChar;
   assign w_padded   = PW'(r_snap);
   assign w_shifted  = w_padded << {r_charIdx, 2'b00};

   // Character currently on the wire: hex digits of the snapshot, then CR, LF.
   always_comb begin
      w_nib  = w_shifted[PW-1 -: 4];
      w_char = 8'h0A;
      if (r_charIdx < 4'(NDIG))
         w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
      else if (r_charIdx == 4'(NDIG))
         w_char = 8'h0D;
      w_parity = (PARITY == 2) ? ~(^w_char) : (^w_char);
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // A pending or simultaneous report chains straight into the next START.
   always_comb begin
      w_next   = r_state;
      w_txNext = 1'b1;
      unique case (r_state)
         IDLE:  if (w_tick) w_next = START;
         START: begin
            w_txNext = 1'b0;
            if (w_bitDone) w_next = DATA;
         end
         DATA: begin
            w_txNext = w_char[r_bitIdx];
            if (w_bitDone && r_bitIdx == 3'd7) w_next = (PARITY != 0) ? PAR : STOP;
         end
         PAR: begin
            w_txNext = w_parity;
            if (w_bitDone) w_next = STOP;
         end
         STOP: if (w_stopDone) w_next = (!w_lastChar || w_tick || r_pending) ? START : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div     <= '0;
         r_led     <= '0;
         r_snap    <= '0;
         r_pendVal <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_clkCnt  <= '0;
         r_bitIdx  <= '0;
         r_charIdx <= '0;
      end else begin
         r_tx   <= w_txNext;
         r_busy <= (r_state != IDLE);
         if (en) r_div <= w_tick ? '0 : r_div + DW'(1);
         if (w_tick) r_led <= w_newVal;

         // A fresh tick always beats an older pending value.
         if (w_tick && r_state == IDLE) begin
            r_snap <= w_newVal;
         end else if (w_frameEnd) begin
            if (w_tick) begin
               r_snap    <= w_newVal;
               r_pending <= 1'b0;
               if (r_pending) r_overrun <= 1'b1;
            end else if (r_pending) begin
               r_snap    <= r_pendVal;
               r_pending <= 1'b0;
            end
         end else if (w_tick) begin
            r_pending <= 1'b1;
            r_pendVal <= w_newVal;
            if (r_pending) r_overrun <= 1'b1;
         end

         if (r_state == IDLE || w_bitDone) r_clkCnt <= '0;
         else                              r_clkCnt <= r_clkCnt + CW'(1);

         if (w_bitDone) begin
            if ((r_state == DATA && r_bitIdx != 3'd7) || (r_state == STOP && !w_stopDone))
               r_bitIdx <= r_bitIdx + 3'd1;
            else
               r_bitIdx <= '0;
         end

         if (w_stopDone) r_charIdx <= w_lastChar ? '0 : r_charIdx + 4'd1;
      end
   end

   assign led     = r_led;
   assign tx      = r_tx;
   assign busy    = r_busy;
   assign overrun = r_overrun;
endmodule
